// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: icache, dcache and memory-side handshake bundle for mem_bus_arbiter.
interface mem_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int LINE_WIDTH = LINE_WORDS * DATA_WIDTH
);
  logic                  ic_req_valid;
  logic                  ic_req_ready;
  logic [ADDR_WIDTH-1:0] ic_req_addr;
  logic                  ic_resp_valid;
  logic [LINE_WIDTH-1:0] ic_resp_line;
  logic                  dc_req_valid;
  logic                  dc_req_ready;
  logic                  dc_req_write;
  logic [ADDR_WIDTH-1:0] dc_req_addr;
  logic [LINE_WIDTH-1:0] dc_req_wline;
  logic                  dc_resp_valid;
  logic [LINE_WIDTH-1:0] dc_resp_line;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_write;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [DATA_WIDTH-1:0] mem_req_wdata;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_resp_rdata;
  modport slave (
    input  ic_req_valid, ic_req_addr, dc_req_valid, dc_req_write, dc_req_addr, dc_req_wline,
           mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output ic_req_ready, ic_resp_valid, ic_resp_line, dc_req_ready, dc_resp_valid, dc_resp_line,
           mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata
  );
  modport master (
    output ic_req_valid, ic_req_addr, dc_req_valid, dc_req_write, dc_req_addr, dc_req_wline,
           mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  ic_req_ready, ic_resp_valid, ic_resp_line, dc_req_ready, dc_resp_valid, dc_resp_line,
           mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin sharing of one word-wide memory port between icache refills and dcache refills/write-backs.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int LINE_WIDTH = LINE_WORDS * DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  mem_bus_arbiter_if.slave bus,
  output logic             busy
);
  localparam int BW = $clog2(LINE_WORDS);
  localparam int WB = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(LINE_WIDTH / 8 - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;
  state_t                state, state_nx;
  logic [BW-1:0]         beat;
  logic                  sel_dc, wr, last_dc;
  logic                  grant_ic, grant_dc, last_beat, accept;
  logic [ADDR_WIDTH-1:0] base, base_in;
  logic [LINE_WIDTH-1:0] line, line_nx, ic_line, dc_line;
  // tie goes to whoever did not win last; last_dc=0 after reset so dcache wins the first tie
  always_comb begin
    grant_dc = state == IDLE && !rst && bus.dc_req_valid && !(bus.ic_req_valid && last_dc);
    grant_ic = state == IDLE && !rst && bus.ic_req_valid && !grant_dc;
    base_in = grant_dc ? bus.dc_req_addr : bus.ic_req_addr;
    last_beat = &beat;
    accept = state == ISSUE && bus.mem_req_ready;
    line_nx = line;
    line_nx[beat*DATA_WIDTH +: DATA_WIDTH] = bus.mem_resp_rdata;
    state_nx = state;
    case (state)
      IDLE:    state_nx = (grant_ic || grant_dc) ? ISSUE : IDLE;
      ISSUE:   state_nx = !accept ? ISSUE : !wr ? WAIT_RD : last_beat ? RESP : ISSUE;
      WAIT_RD: state_nx = !bus.mem_resp_valid ? WAIT_RD : last_beat ? RESP : ISSUE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      beat    <= '0;
      sel_dc  <= 1'b0;
      wr      <= 1'b0;
      last_dc <= 1'b0;
      base    <= '0;
      line    <= '0;
      ic_line <= '0;
      dc_line <= '0;
    end else begin
      state <= state_nx;
      if (grant_ic || grant_dc) begin
        sel_dc  <= grant_dc;
        wr      <= grant_dc && bus.dc_req_write;
        base    <= base_in & ~OFF_MASK;
        line    <= bus.dc_req_wline;
        last_dc <= grant_dc;
        beat    <= '0;
      end
      if (accept && wr && !last_beat) beat <= beat + 1'b1;
      // one read beat outstanding at a time, so the returned word always belongs to the current beat
      if (state == WAIT_RD && bus.mem_resp_valid) begin
        line <= line_nx;
        if (!last_beat) beat <= beat + 1'b1;
        else if (sel_dc) dc_line <= line_nx;
        else ic_line <= line_nx;
      end
    end
  end
  assign busy              = state != IDLE;
  assign bus.ic_req_ready  = grant_ic;
  assign bus.dc_req_ready  = grant_dc;
  assign bus.ic_resp_valid = state == RESP && !sel_dc;
  assign bus.dc_resp_valid = state == RESP && sel_dc;
  assign bus.ic_resp_line  = ic_line;
  assign bus.dc_resp_line  = dc_line;
  assign bus.mem_req_valid = state == ISSUE;
  assign bus.mem_req_write = state == ISSUE && wr;
  assign bus.mem_req_addr  = state == ISSUE ? base | (ADDR_WIDTH'(beat) << WB) : '0;
  assign bus.mem_req_wdata = (state == ISSUE && wr) ? line[beat*DATA_WIDTH +: DATA_WIDTH] : '0;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: vector table, directed corner sequences and randomized traffic checked against a line-level memory model.
module tb_mem_bus_arbiter;
  localparam int LW = 128;
  typedef struct { logic wr; logic [31:0] addr; logic [LW-1:0] wline; } req_t;
  typedef struct { bit dc; bit wr; logic [31:0] addr; logic [LW-1:0] wline; logic [31:0] base; logic [LW-1:0] line; int lat; } vec_t;
  logic clk = 0, rst = 1, busy;
  always #5 clk = ~clk;
  mem_bus_arbiter_if bus ();
  mem_bus_arbiter dut (.clk(clk), .rst(rst), .bus(bus.slave), .busy(busy));
  int checks = 0, failures = 0, cyc = 0;
  int ready_pct = 100, lat_lo = 1, lat_hi = 1, stall_beat = -1, stall_n = 0;
  bit stray_en = 0, rd_pending = 0;
  int rd_delay = 0;
  logic [31:0] rd_addr = 0;
  logic [31:0] shadow [logic [31:0]];
  req_t ic_q[$], dc_q[$];
  bit o_icr = 0, o_dcr = 0, o_icv = 0, o_dcv = 0, o_beat = 0;
  bit cur_active = 0, cur_dc = 0, cur_wr = 0, last_dc = 0;
  logic [31:0] cur_base = 0, first_addr = 0;
  logic [LW-1:0] cur_line = 0, last_ic_line = 0;
  int beats = 0, grant_cyc = 0, resp_cyc = 0, done_cnt = 0, ready_cnt = 0, resp_cnt = 0;
  bit grant_log[$];
  task automatic check(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic logic [31:0] mem_rd(logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : (a * 32'h9E3779B9) ^ 32'h5A5A0F0F;
  endfunction
  function automatic logic [LW-1:0] model_line(logic [31:0] b);
    logic [LW-1:0] l;
    for (int k = 0; k < 4; k++) l[32*k +: 32] = mem_rd(b + 32'(4*k));
    return l;
  endfunction
  // one clock: drive requesters and memory at negedge, then observe what the next posedge will take
  task automatic tick();
    req_t r;
    bit exp_dc;
    @(negedge clk);
    cyc++;
    if (o_icr) bus.ic_req_valid = 0;
    if (o_dcr) bus.dc_req_valid = 0;
    if (!bus.ic_req_valid && ic_q.size() > 0) begin
      r = ic_q.pop_front();
      bus.ic_req_valid = 1;
      bus.ic_req_addr = r.addr;
    end
    if (!bus.dc_req_valid && dc_q.size() > 0) begin
      r = dc_q.pop_front();
      bus.dc_req_valid = 1;
      bus.dc_req_write = r.wr;
      bus.dc_req_addr = r.addr;
      bus.dc_req_wline = r.wline;
    end
    bus.mem_resp_valid = 0;
    if (rd_pending) begin
      if (rd_delay == 0) begin
        bus.mem_resp_valid = 1;
        bus.mem_resp_rdata = mem_rd(rd_addr);
        rd_pending = 0;
      end else rd_delay--;
    end else if (stray_en) begin
      bus.mem_resp_valid = 1;
      bus.mem_resp_rdata = $urandom;
    end
    #1;
    if (stall_n > 0 && bus.mem_req_valid && beats == stall_beat) begin
      bus.mem_req_ready = 0;
      stall_n--;
    end else bus.mem_req_ready = ($urandom_range(99) < ready_pct);
    #1;
    o_icr = bus.ic_req_ready;
    o_dcr = bus.dc_req_ready;
    o_icv = bus.ic_resp_valid;
    o_dcv = bus.dc_resp_valid;
    o_beat = bus.mem_req_valid && bus.mem_req_ready;
    if (o_icr || o_dcr) begin
      exp_dc = (bus.ic_req_valid && bus.dc_req_valid) ? !last_dc : bus.dc_req_valid;
      check("grant_sel", {o_icr, o_dcr}, exp_dc ? 2'b01 : 2'b10);
      check("grant_when_idle", cur_active, 0);
      ready_cnt++;
      last_dc = o_dcr;
      cur_active = 1;
      cur_dc = o_dcr;
      cur_wr = o_dcr && bus.dc_req_write;
      cur_base = (o_dcr ? bus.dc_req_addr : bus.ic_req_addr) & ~32'hF;
      cur_line = cur_wr ? bus.dc_req_wline : model_line(cur_base);
      beats = 0;
      grant_cyc = cyc;
      grant_log.push_back(o_dcr);
    end
    if (o_beat) begin
      check("beat_in_txn", cur_active, 1);
      if (beats == 0) first_addr = bus.mem_req_addr;
      check("beat_addr", bus.mem_req_addr, cur_base + 32'(4*beats));
      check("beat_write", bus.mem_req_write, cur_wr);
      if (cur_wr) begin
        check("beat_wdata", bus.mem_req_wdata, cur_line[32*beats +: 32]);
        shadow[bus.mem_req_addr] = bus.mem_req_wdata;
      end else begin
        rd_pending = 1;
        rd_addr = bus.mem_req_addr;
        rd_delay = $urandom_range(lat_hi - 1, lat_lo - 1);
      end
      beats++;
    end
    if (o_icv || o_dcv) begin
      resp_cnt++;
      check("resp_in_txn", cur_active, 1);
      check("resp_sel", {o_icv, o_dcv}, cur_dc ? 2'b01 : 2'b10);
      check("resp_beats", beats, 4);
      if (!cur_wr) begin
        check("resp_line", cur_dc ? bus.dc_resp_line : bus.ic_resp_line, cur_line);
        if (!cur_dc) last_ic_line = cur_line;
      end
      cur_active = 0;
      resp_cyc = cyc;
      done_cnt++;
    end
  endtask
  task automatic run_until(int target, int bound);
    int n = 0;
    while (done_cnt < target && n < bound) begin
      tick();
      n++;
    end
    if (done_cnt < target) check("done_timeout", done_cnt, target);
  endtask
  task automatic do_reset();
    rst = 1;
    bus.ic_req_valid = 0;
    bus.dc_req_valid = 0;
    ic_q.delete();
    dc_q.delete();
    cur_active = 0;
    rd_pending = 0;
    last_dc = 0;
    stall_n = 0;
    repeat (2) tick();
    rst = 0;
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t vecs[6];
    req_t r;
    logic [LW-1:0] bline;
    int d0, rc, n, issued;
    bit dc;
    bus.ic_req_valid = 0; bus.ic_req_addr = 0;
    bus.dc_req_valid = 0; bus.dc_req_write = 0; bus.dc_req_addr = 0; bus.dc_req_wline = 0;
    bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_resp_rdata = 0;
    shadow[32'h1000] = 32'h11; shadow[32'h1004] = 32'h22; shadow[32'h1008] = 32'h33; shadow[32'h100C] = 32'h44;
    vecs[0] = '{0, 0, 32'h1004, '0, 32'h1000, 128'h00000044_00000033_00000022_00000011, 9};
    vecs[1] = '{1, 1, 32'h2000, 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0, 32'h2000, '0, 5};
    vecs[2] = '{1, 0, 32'h2008, '0, 32'h2000, 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0, 9};
    vecs[3] = '{0, 0, 32'h200C, '0, 32'h2000, 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0, 9};
    vecs[4] = '{1, 1, 32'h3FFC, 128'hDEAD0003_DEAD0002_DEAD0001_DEAD0000, 32'h3FF0, '0, 5};
    vecs[5] = '{0, 0, 32'h3FF4, '0, 32'h3FF0, 128'hDEAD0003_DEAD0002_DEAD0001_DEAD0000, 9};
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_mem_valid", bus.mem_req_valid, 0);
    check("rst_mem_addr", bus.mem_req_addr, 0);
    check("rst_ic_ready", bus.ic_req_ready, 0);
    check("rst_dc_ready", bus.dc_req_ready, 0);
    check("rst_resp_valid", {bus.ic_resp_valid, bus.dc_resp_valid}, 0);
    check("rst_lines", {bus.ic_resp_line, bus.dc_resp_line} != 0, 0);
    for (int i = 0; i < 6; i++) begin
      d0 = done_cnt;
      r = '{vecs[i].wr, vecs[i].addr, vecs[i].wline};
      if (vecs[i].dc) dc_q.push_back(r); else ic_q.push_back(r);
      run_until(d0 + 1, 60);
      check($sformatf("vec%0d_base", i), first_addr, vecs[i].base);
      check($sformatf("vec%0d_latency", i), resp_cyc - grant_cyc, vecs[i].lat);
      check($sformatf("vec%0d_requester", i), cur_dc, vecs[i].dc);
      if (!vecs[i].wr) check($sformatf("vec%0d_line", i), vecs[i].dc ? bus.dc_resp_line : bus.ic_resp_line, vecs[i].line);
      tick();
    end
    bline = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
    stall_beat = 1; stall_n = 3; rc = 0; d0 = done_cnt; n = 0;
    dc_q.push_back('{1, 32'h5000, bline});
    while (done_cnt < d0 + 1 && n < 60) begin
      tick();
      n++;
      if (bus.mem_req_valid && !bus.mem_req_ready) begin
        rc++;
        check("stall_addr", bus.mem_req_addr, 32'h5004);
        check("stall_wdata", bus.mem_req_wdata, bline[63:32]);
      end
    end
    if (done_cnt < d0 + 1) check("stall_timeout", done_cnt, d0 + 1);
    check("stall_cycles", rc, 3);
    check("stall_latency", resp_cyc - grant_cyc, 8);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ic_q.push_back('{0, 32'h6000 + 32'(i*16), '0});
      dc_q.push_back('{i == 1, 32'h7000 + 32'(i*16), {$urandom, $urandom, $urandom, $urandom}});
    end
    grant_log.delete();
    d0 = done_cnt; rc = ready_cnt;
    run_until(d0 + 6, 200);
    check("tie_grants", grant_log.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < grant_log.size()) check($sformatf("tie_order%0d", i), grant_log[i], i % 2 == 0);
    check("tie_ready_count", ready_cnt - rc, 6);
    tick();
    rc = resp_cnt; stray_en = 1;
    repeat (5) tick();
    stray_en = 0;
    check("stray_idle_resp", resp_cnt - rc, 0);
    check("stray_idle_line", bus.ic_resp_line, last_ic_line);
    ready_pct = 0; stray_en = 1; d0 = done_cnt;
    ic_q.push_back('{0, 32'h1000, '0});
    repeat (4) tick();
    check("stray_issue_busy", busy, 1);
    check("stray_issue_valid", bus.mem_req_valid, 1);
    check("stray_issue_resp", resp_cnt - rc, 0);
    ready_pct = 100;
    run_until(d0 + 1, 60);
    stray_en = 0;
    check("stray_line", bus.ic_resp_line, 128'h00000044_00000033_00000022_00000011);
    check("stray_resp_count", resp_cnt - rc, 1);
    lat_lo = 3; lat_hi = 3; rc = resp_cnt; n = 0;
    ic_q.push_back('{0, 32'h9004, '0});
    tick();
    while (!(cur_active && beats == 3) && n < 60) begin
      tick();
      n++;
    end
    check("mid_reached_beat2", beats, 3);
    tick();
    check("mid_wait_busy", busy, 1);
    check("mid_wait_no_req", bus.mem_req_valid, 0);
    rst = 1; cur_active = 0; last_dc = 0;
    tick();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_mem_valid", bus.mem_req_valid, 0);
    check("mid_rst_mem_addr", bus.mem_req_addr, 0);
    check("mid_rst_resp_valid", {bus.ic_resp_valid, bus.dc_resp_valid}, 0);
    check("mid_rst_ic_line", bus.ic_resp_line, 0);
    check("mid_rst_dc_line", bus.dc_resp_line, 0);
    rst = 0;
    repeat (4) tick();
    check("mid_rst_no_resp", resp_cnt - rc, 0);
    lat_lo = 1; lat_hi = 1; d0 = done_cnt;
    ic_q.push_back('{0, 32'h9000, '0});
    run_until(d0 + 1, 60);
    check("post_rst_latency", resp_cyc - grant_cyc, 9);
    check("post_rst_line", bus.ic_resp_line, model_line(32'h9000));
    ready_pct = 70; lat_lo = 1; lat_hi = 3; issued = 0; d0 = done_cnt; n = 0;
    while ((issued < 60 || done_cnt < d0 + issued) && n < 6000) begin
      if (issued < 60 && $urandom_range(3) == 0) begin
        dc = $urandom_range(1) == 1;
        r.wr = dc && $urandom_range(1) == 1;
        r.addr = 32'h8000 + ($urandom_range(15) << 4) + $urandom_range(15);
        r.wline = {$urandom, $urandom, $urandom, $urandom};
        if (dc) dc_q.push_back(r); else ic_q.push_back(r);
        issued++;
      end
      stray_en = $urandom_range(4) == 0;
      tick();
      n++;
    end
    stray_en = 0;
    check("rand_completed", done_cnt - d0, issued);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single main-memory port between the instruction cache (read-only line refills) and the data cache (line refills and line write-backs).
- Grants one requester at a time using round-robin arbitration.
- Serialises each cache line into word beats on the memory side. For reads it assembles returned beats into a line buffer, then returns the full line to the granted cache.
- Sits between both caches and the memory model/bus.

Parameters:
- ADDR_WIDTH, 32: byte address width.
- DATA_WIDTH, 32: memory beat width in bits.
- LINE_WORDS, 4: words per cache line. Must be a power of two, ≥2.
- LINE_WIDTH, LINE_WORDS*DATA_WIDTH: derived; packed line width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- ic_req_valid  in  1  icache line-read request.
- ic_req_ready  out  1  1-cycle pulse: icache request latched.
- ic_req_addr  in  ADDR_WIDTH  icache request address. Low offset bits are ignored.
- ic_resp_valid  out  1  1-cycle pulse: ic_resp_line valid.
- ic_resp_line  out  LINE_WIDTH  refilled line; word k at bits [DATA_WIDTH*k +: DATA_WIDTH].
- dc_req_valid  in  1  dcache request.
- dc_req_ready  out  1  1-cycle pulse: dcache request latched.
- dc_req_write  in  1  1 = write-back, 0 = refill.
- dc_req_addr  in  ADDR_WIDTH  dcache request address.
- dc_req_wline  in  LINE_WIDTH  write-back line data.
- dc_resp_valid  out  1  1-cycle pulse: dcache transaction complete. For reads, dc_resp_line is valid.
- dc_resp_line  out  LINE_WIDTH  refilled line.
- mem_req_valid  out  1  beat request to memory.
- mem_req_ready  in  1  memory accepts beat.
- mem_req_write  out  1  beat is a write.
- mem_req_addr  out  ADDR_WIDTH  beat byte address.
- mem_req_wdata  out  DATA_WIDTH  write beat data.
- mem_resp_valid  in  1  read beat returned. Memory latency is at least 1 cycle after acceptance.
- mem_resp_rdata  in  DATA_WIDTH  read beat data.
- busy  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (rst high at posedge):
  - All outputs go to 0, including the resp_line registers.
  - FSM goes to IDLE, beat counter to 0, last_grant to ICACHE.
  - An in-flight transaction is abandoned: no resp pulse, no further beats.
- FSM states: IDLE, ISSUE, WAIT_RD, RESP.
- IDLE:
  - If no requester is valid, stay in IDLE.
  - If one requester is valid, grant it.
  - If both are valid, grant the one that is not last_grant. After reset the dcache therefore wins the first tie.
  - On a grant:
    - Pulse the winner's req_ready for exactly one cycle.
    - Latch the winner's id, write flag (icache is always read), line-aligned base address (offset bits zeroed) and wline.
    - Update last_grant, clear the beat counter, go to ISSUE.
- ISSUE:
  - Drive mem_req_valid=1 and mem_req_write=latched write flag.
  - mem_req_addr = base | (beat*DATA_WIDTH/8).
  - For writes, mem_req_wdata = word[beat] of the latched line.
  - On mem_req_valid && mem_req_ready:
    - Read: go to WAIT_RD.
    - Write, not last beat: beat++ and stay in ISSUE, so back-to-back beats are allowed.
    - Write, last beat (beat==LINE_WORDS-1): go to RESP.
  - mem_req_valid and all beat fields stay stable until accepted.
- WAIT_RD:
  - mem_req_valid=0.
  - On mem_resp_valid, write mem_resp_rdata into line-buffer word[beat].
  - Last beat: go to RESP. Otherwise beat++ and go to ISSUE.
  - Only one read beat is outstanding at a time.
- RESP:
  - Pulse resp_valid for the granted requester for one cycle.
  - For reads, the matching resp_line holds the assembled buffer.
  - Go to IDLE.
  - resp_line registers hold their value until the next read completion for that requester.
- mem_resp_valid outside WAIT_RD is ignored. Requests arriving while busy wait; no req_ready is given.
- Requesters hold req_valid and their request fields until req_ready, then drop req_valid. A requester still holding valid in the cycle after its RESP is treated as a new request.
- Latency with mem_req_ready=1 and 1-cycle memory read latency (request seen at cycle 0):
  - Read: resp pulse at cycle 1+2*LINE_WORDS (cycle 9 for 4 words).
  - Write: resp pulse at cycle 1+LINE_WORDS (cycle 5).
- Arbitration is decided only in IDLE. A grant is never preempted.

Test Plan:
- Icache read, base 0x0000_1004, memory returns 0x11,0x22,0x33,0x44 -> beat addresses 0x1000,0x1004,0x1008,0x100C; ic_resp_valid at cycle 9; ic_resp_line=0x00000044_00000033_00000022_00000011; dc outputs idle.
- Dcache write-back, addr 0x2000, wline words A0..A3, mem_req_ready=1 -> 4 consecutive write beats 0x2000..0x200C carrying A0..A3; dc_resp_valid at cycle 5.
- Write with mem_req_ready low for 3 cycles on beat 1 -> beat 1 address and data held stable for 3 cycles; no beat skipped or duplicated.
- Both requesters valid from reset, each issuing 3 back-to-back requests -> grant order dc, ic, dc, ic, dc, ic; exactly one req_ready per grant.
- Stray mem_resp_valid during IDLE and ISSUE -> ignored; line buffer unchanged; no resp pulse.
- rst asserted during WAIT_RD of beat 2 -> next cycle all outputs 0, busy=0, no resp pulse; a following icache request completes normally.
